// File: rtl/des_round_sequencer.sv
// Sequences the Feistel rounds of one DES block through an external round function
// and key schedule, then presents the swapped pre-FP halves with valid/ready handshake.
module des_round_sequencer #(
  parameter int unsigned N_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic        abort,
  input  logic [31:0] L0,
  input  logic [31:0] R0,
  output logic        ready,
  output logic [3:0]  key_idx,
  input  logic [47:0] Kn,
  output logic        rf_enable,
  output logic        rf_i_valid,
  output logic        rf_restart,
  output logic [31:0] rf_L_in,
  output logic [31:0] rf_R_in,
  output logic [47:0] rf_Kn,
  input  logic        rf_o_valid,
  input  logic [31:0] rf_L_out,
  input  logic [31:0] rf_R_out,
  output logic        o_valid,
  input  logic        out_ready,
  output logic [31:0] L_out,
  output logic [31:0] R_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS - 1);

  state_t      state, state_nxt;
  logic [31:0] L_reg, R_reg, L_nxt, R_nxt;
  logic [3:0]  round, round_nxt;
  logic        decrypt_reg, decrypt_nxt;
  logic        restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      L_reg       <= '0;
      R_reg       <= '0;
      round       <= '0;
      decrypt_reg <= 1'b0;
    end else begin
      state       <= state_nxt;
      L_reg       <= L_nxt;
      R_reg       <= R_nxt;
      round       <= round_nxt;
      decrypt_reg <= decrypt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    L_nxt       = L_reg;
    R_nxt       = R_reg;
    round_nxt   = round;
    decrypt_nxt = decrypt_reg;
    rf_enable   = 1'b0;
    rf_i_valid  = 1'b0;
    restart     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          L_nxt       = L0;
          R_nxt       = R0;
          decrypt_nxt = decrypt;
          round_nxt   = '0;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        rf_enable  = 1'b1;
        rf_i_valid = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        rf_enable = 1'b1;
        if (rf_o_valid) begin
          L_nxt = rf_L_out;
          R_nxt = rf_R_out;
          if (round == LAST_ROUND) begin
            state_nxt = DONE;
          end else begin
            round_nxt = round + 4'd1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          restart   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition above, including a round result landing this cycle.
    if (abort) begin
      state_nxt   = IDLE;
      round_nxt   = '0;
      L_nxt       = L_reg;
      R_nxt       = R_reg;
      decrypt_nxt = decrypt_reg;
      restart     = 1'b1;
    end
  end

  assign rf_restart = restart & rst_n;
  assign ready      = (state == IDLE);
  assign o_valid    = (state == DONE);
  assign key_idx    = decrypt_reg ? (LAST_ROUND - round) : round;
  assign rf_L_in    = L_reg;
  assign rf_R_in    = R_reg;
  assign rf_Kn      = Kn;
  // Final Feistel swap: the last round leaves the halves crossed.
  assign L_out      = o_valid ? R_reg : '0;
  assign R_out      = o_valid ? L_reg : '0;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: table-driven DES key schedule and round function
// models, scoreboard of expected results checked by an independent monitor.
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, decrypt, abort, out_ready;
  logic [31:0] L0, R0;
  logic        ready, rf_enable, rf_i_valid, rf_restart, o_valid;
  logic [3:0]  key_idx;
  logic [47:0] Kn, rf_Kn;
  logic [31:0] rf_L_in, rf_R_in, L_out, R_out;
  logic        rf_o_valid;
  logic [31:0] rf_L_out, rf_R_out;

  des_round_sequencer #(.N_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
    .L0(L0), .R0(R0), .ready(ready), .key_idx(key_idx), .Kn(Kn),
    .rf_enable(rf_enable), .rf_i_valid(rf_i_valid), .rf_restart(rf_restart),
    .rf_L_in(rf_L_in), .rf_R_in(rf_R_in), .rf_Kn(rf_Kn),
    .rf_o_valid(rf_o_valid), .rf_L_out(rf_L_out), .rf_R_out(rf_R_out),
    .o_valid(o_valid), .out_ready(out_ready), .L_out(L_out), .R_out(R_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Subkeys K1..K16 for key 133457799BBCDFF1, indexed by key_idx.
  logic [47:0] ktab [16];
  // rc[0]=L0, rc[1]=R0, rc[k+1]=R_k of the reference encryption.
  logic [31:0] rc [18];
  logic [31:0] fR [16];
  logic [47:0] fK [16];
  logic [31:0] fV [16];

  assign Kn = ktab[key_idx];

  typedef struct { logic [31:0] l; logic [31:0] r; int lat; } exp_t;
  exp_t sb[$];
  time  start_t;

  // Round function model: answers after 1 cycle (plus stall cycles in round 4 when enabled).
  bit          pend, stall_en, found;
  int          cnt, exp_kidx, kdir;
  logic [3:0]  issue_idx;
  logic [31:0] pL, pR, fval;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend       = 1'b0;
      rf_o_valid = 1'b0;
    end else begin
      rf_o_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          rf_o_valid = 1'b1;
          rf_L_out   = pL;
          rf_R_out   = pR;
          pend       = 1'b0;
        end else begin
          chk("stall_key_idx", key_idx, issue_idx);
          chk("stall_i_valid", rf_i_valid, 0);
          cnt--;
        end
      end
      if (rf_i_valid) begin
        found = 1'b0;
        fval  = '0;
        for (int i = 0; i < 16; i++)
          if (fR[i] == rf_R_in && fK[i] == rf_Kn) begin
            found = 1'b1;
            fval  = fV[i];
          end
        chk("rf_lookup_hit", found, 1);
        chk("key_idx_issue", key_idx, 64'(exp_kidx));
        exp_kidx  += kdir;
        issue_idx = key_idx;
        cnt       = (stall_en && key_idx == 4'd4) ? 3 : 0;
        pL        = rf_R_in;
        pR        = rf_L_in ^ fval;
        pend      = 1'b1;
      end
    end
  end

  // Monitor: compare each fresh o_valid against the oldest expectation.
  bit ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst_n && o_valid && !ov_prev) begin
      if (sb.size() == 0) chk("o_valid_unexpected", o_valid, 0);
      else begin
        e   = sb.pop_front();
        lat = int'(($time - start_t - 5) / 10);
        chk("L_out", L_out, e.l);
        chk("R_out", R_out, e.r);
        chk("latency", 64'(lat), 64'(e.lat));
      end
    end
    ov_prev = o_valid;
  end

  task automatic run_block(input logic [31:0] l, input logic [31:0] r, input logic dec,
                           input logic [31:0] el, input logic [31:0] er, input int lat,
                           input bit push);
    exp_kidx = dec ? 15 : 0;
    kdir     = dec ? -1 : 1;
    if (push) sb.push_back('{el, er, lat});
    @(negedge clk);
    L0 = l; R0 = r; decrypt = dec; start = 1'b1;
    @(posedge clk);
    start_t = $time;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  bit          ok;
  logic [31:0] lo, ro;

  initial begin
    ktab[0]  = 48'h1B02EFFC7072; ktab[1]  = 48'h79AED9DBC9E5;
    ktab[2]  = 48'h55FC8A42CF99; ktab[3]  = 48'h72ADD6DB351D;
    ktab[4]  = 48'h7CEC07EB53A8; ktab[5]  = 48'h63A53E507B2F;
    ktab[6]  = 48'hEC84B7F618BC; ktab[7]  = 48'hF78A3AC13BFB;
    ktab[8]  = 48'hE0DBEBEDE781; ktab[9]  = 48'hB1F347BA464F;
    ktab[10] = 48'h215FD3DED386; ktab[11] = 48'h7571F59467E9;
    ktab[12] = 48'h97C5D1FAEA41; ktab[13] = 48'h5F43B7F2E73A;
    ktab[14] = 48'hBF918D3D3F0A; ktab[15] = 48'hCB3D8B0E17F5;
    rc[0]  = 32'hCC00CCFF; rc[1]  = 32'hF0AAF0AA; rc[2]  = 32'hEF4A6544;
    rc[3]  = 32'hCC017709; rc[4]  = 32'hA25C0BF4; rc[5]  = 32'h77220045;
    rc[6]  = 32'h8A4FA637; rc[7]  = 32'hE967CD69; rc[8]  = 32'h064ABA10;
    rc[9]  = 32'hD5694B90; rc[10] = 32'h247CC67A; rc[11] = 32'hB7D5D7B2;
    rc[12] = 32'hC5783C78; rc[13] = 32'h75BD1858; rc[14] = 32'h18C3155A;
    rc[15] = 32'hC28C960D; rc[16] = 32'h43423234; rc[17] = 32'h0A4CD995;
    // f(R_{i-1}, K_i) = R_i ^ L_{i-1}, with L_{i-1} = R_{i-2}.
    for (int i = 1; i <= 16; i++) begin
      fR[i-1] = rc[i];
      fK[i-1] = ktab[i-1];
      fV[i-1] = rc[i+1] ^ rc[i-1];
    end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
    L0 = '0; R0 = '0; rf_L_out = '0; rf_R_out = '0; rf_o_valid = 1'b0;
    stall_en = 1'b0; exp_kidx = 0; kdir = 1;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_rf_enable", rf_enable, 0);
    chk("rst_rf_i_valid", rf_i_valid, 0);
    chk("rst_rf_restart", rf_restart, 0);
    chk("rst_key_idx", key_idx, 0);
    chk("rst_L_out", L_out, 0);
    chk("rst_R_out", R_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Encrypt and decrypt of the reference block.
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'h0A4CD995, 32'h43423234, 32, 1'b1);
    wait_drain("drain_encrypt");
    run_block(32'h0A4CD995, 32'h43423234, 1'b1, 32'hCC00CCFF, 32'hF0AAF0AA, 32, 1'b1);
    wait_drain("drain_decrypt");

    // Backpressure in DONE; start is ignored there and on the exit cycle.
    out_ready = 1'b0;
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'h0A4CD995, 32'h43423234, 32, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_valid) begin ok = 1'b1; break; end
    end
    chk("bp_reach_done", ok, 1);
    lo = L_out; ro = R_out;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      L0    = 32'hDEAD0000 + i;
      @(negedge clk);
      chk("bp_o_valid", o_valid, 1);
      chk("bp_L_stable", L_out, lo);
      chk("bp_R_stable", R_out, ro);
      chk("bp_ready", ready, 0);
    end
    start = 1'b1; out_ready = 1'b1;
    #1 chk("bp_restart_pulse", rf_restart, 1);
    @(negedge clk);
    chk("bp_ready_after", ready, 1);
    chk("bp_restart_single", rf_restart, 0);
    start = 1'b0;
    wait_drain("drain_bp");

    // Abort in the WAIT phase of round 7, then a clean block.
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rf_enable && !rf_i_valid && key_idx == 4'd7) begin ok = 1'b1; break; end
    end
    chk("ab_reach_r7", ok, 1);
    abort = 1'b1;
    #1 chk("ab_restart", rf_restart, 1);
    @(posedge clk);
    #1 abort = 1'b0;
    #1;
    chk("ab_ready", ready, 1);
    chk("ab_key_idx", key_idx, 0);
    chk("ab_rf_enable", rf_enable, 0);
    chk("ab_restart_drop", rf_restart, 0);
    repeat (40) @(negedge clk);
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'h0A4CD995, 32'h43423234, 32, 1'b1);
    wait_drain("drain_after_abort");

    // Round-function stall of 3 cycles in round 4.
    stall_en = 1'b1;
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'h0A4CD995, 32'h43423234, 35, 1'b1);
    wait_drain("drain_stall");
    stall_en = 1'b0;

    // Asynchronous reset during round 10 of a decrypt.
    run_block(32'h0A4CD995, 32'h43423234, 1'b1, 32'h0, 32'h0, 0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rf_i_valid && key_idx == 4'd5) begin ok = 1'b1; break; end
    end
    chk("rs_reach_r10", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_ready", ready, 1);
    chk("rs_o_valid", o_valid, 0);
    chk("rs_rf_enable", rf_enable, 0);
    chk("rs_rf_i_valid", rf_i_valid, 0);
    chk("rs_rf_restart", rf_restart, 0);
    chk("rs_key_idx", key_idx, 0);
    chk("rs_L_out", L_out, 0);
    chk("rs_R_out", R_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rs_ready_release", ready, 1);
    repeat (40) @(negedge clk);
    run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'h0A4CD995, 32'h43423234, 32, 1'b1);
    wait_drain("drain_after_reset");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and reset SHALL be asynchronous and active-low on rst_n.
REQ-002 Parameter N_ROUNDS, default 16, SHALL set the number of Feistel rounds per block.
REQ-003 The ports SHALL be as follows, one per line, as name  direction  width  meaning:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- start  in  1  request to process one block
- decrypt  in  1  0 = encrypt key order, 1 = reverse; sampled with start
- abort  in  1  synchronous cancel
- L0, R0  in  32 each  post-IP halves; sampled with start
- ready  out  1  high only in IDLE
- key_idx  out  4  subkey index to the external key schedule
- Kn  in  48  subkey for key_idx, combinational from the key schedule
- rf_enable, rf_i_valid, rf_restart  out  1 each  round-function controls
- rf_L_in, rf_R_in  out  32 each  round-function inputs
- rf_Kn  out  48  round-function subkey
- rf_o_valid  in  1  round-function output valid
- rf_L_out, rf_R_out  in  32 each  round-function outputs
- o_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- L_out, R_out  out  32 each  pre-FP result

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-005 In IDLE with start=1 at a rising edge, the block SHALL latch L0 into L_reg, R0 into R_reg and decrypt, clear round to 0, and go to ISSUE; start SHALL be ignored in every other state.
REQ-006 In ISSUE, the block SHALL drive rf_enable=1, rf_i_valid=1, rf_L_in=L_reg, rf_R_in=R_reg and rf_Kn=Kn, then go to WAIT unconditionally.
REQ-007 In WAIT, the block SHALL drive rf_enable=1 and rf_i_valid=0.
REQ-008 In WAIT with rf_o_valid=1, the block SHALL latch rf_L_out into L_reg and rf_R_out into R_reg.
REQ-009 In WAIT with rf_o_valid=1, the block SHALL go to DONE if round==N_ROUNDS-1, and otherwise increment round and go to ISSUE.
REQ-010 In WAIT with rf_o_valid=0, the block SHALL stay in WAIT with L_reg, R_reg and round held.
REQ-011 In IDLE and DONE, rf_enable and rf_i_valid SHALL be 0.
REQ-012 key_idx SHALL equal round when decrypt_reg=0 and N_ROUNDS-1-round when decrypt_reg=1, in all states.
REQ-013 round SHALL be a 4-bit counter that never wraps; it only resets to 0 on start, abort or reset.
REQ-014 In DONE, o_valid SHALL be 1, L_out SHALL equal R_reg and R_out SHALL equal L_reg (final swap).
REQ-015 L_out and R_out SHALL hold stable while DONE is held.
REQ-016 In DONE with out_ready=1, the block SHALL go to IDLE and assert rf_restart for exactly that one cycle (combinational on the transition).
REQ-017 With a one-cycle round function, o_valid SHALL rise exactly 2*N_ROUNDS rising edges after the edge that accepts start (32 at the default).
REQ-018 abort=1 in any state SHALL force IDLE at the next edge, clear round, drop o_valid and assert rf_restart that cycle.
REQ-019 abort SHALL take priority over out_ready, rf_o_valid and start.
REQ-020 start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-021 When DONE exits to IDLE on out_ready=1, start SHALL NOT be accepted in that same cycle; the earliest acceptance is the next cycle.
REQ-022 rf_o_valid=1 seen outside WAIT SHALL be ignored.

Reset
REQ-023 While rst_n=0, the block SHALL be in IDLE with round=0 and decrypt_reg=0.
REQ-024 While rst_n=0, L_reg and R_reg SHALL be 0.
REQ-025 While rst_n=0, the outputs SHALL be: o_valid=0, rf_enable=0, rf_i_valid=0, rf_restart=0, ready=1, key_idx=0, L_out=0, R_out=0.
REQ-026 Reset asserted mid-operation SHALL discard the block in progress immediately, with no o_valid pulse.

Verification
REQ-027 Encrypt scenario: a key schedule model for key 133457799BBCDFF1, L0=CC00CCFF, R0=F0AAF0AA and decrypt=0 -> L_out=0A4CD995 and R_out=43423234, with o_valid rising 32 cycles after start.
REQ-028 Decrypt scenario: the same key, L0=0A4CD995, R0=43423234 and decrypt=1 -> L_out=CC00CCFF and R_out=F0AAF0AA; key_idx steps 15,14,...,0 on the ISSUE cycles.
REQ-029 Backpressure scenario: out_ready held 0 for 10 cycles in DONE -> o_valid and L_out/R_out stable throughout, ready=0, and start pulses ignored; then out_ready=1 -> one rf_restart pulse and ready=1 on the next cycle.
REQ-030 Abort scenario: abort in WAIT of round 7 -> IDLE next cycle, rf_restart pulse, round=0, no o_valid; a following start produces the correct encryption result.
REQ-031 Stall scenario: rf_o_valid delayed 3 cycles in round 4 -> WAIT holds, key_idx stays at 4, and total latency is 35 cycles with an unchanged result.
REQ-032 Reset scenario: rst_n pulsed low in round 10 -> all outputs take their reset values asynchronously, and ready=1 after release.
